// File: rtl/ame_pkg.sv
// rtl/ame_pkg.sv - shared types for the affine-ME gradient correlation stage
package ame_pkg;

  localparam int COMP_DATA_BITS = 11;
  localparam int SUM_DATA_BITS  = 26;

  typedef logic signed [COMP_DATA_BITS-1:0] grad_t;
  typedef grad_t     [3:0] grad_row_t;
  typedef grad_row_t [3:0] grad_blk_t;
  typedef logic signed [SUM_DATA_BITS-1:0]  sum_t;

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Widen before multiplying so the product keeps its sign and full precision.
  function automatic sum_t mul_ext(input grad_t a, input grad_t b);
    return sum_t'(a) * sum_t'(b);
  endfunction

endpackage

// File: rtl/ame_grad_row_mac.sv
// rtl/ame_grad_row_mac.sv - one row (4 pixels) of gx*gx, gy*gy and gx*gy partial sums
module ame_grad_row_mac
  import ame_pkg::*;
(
  input  grad_row_t gx_i,
  input  grad_row_t gy_i,
  output sum_t      xx_o,
  output sum_t      yy_o,
  output sum_t      xy_o
);

  always_comb begin
    xx_o = '0;
    yy_o = '0;
    xy_o = '0;
    for (int c = 0; c < 4; c++) begin
      xx_o = xx_o + mul_ext(gx_i[c], gx_i[c]);
      yy_o = yy_o + mul_ext(gy_i[c], gy_i[c]);
      xy_o = xy_o + mul_ext(gx_i[c], gy_i[c]);
    end
  end

endmodule

// File: rtl/ame_grad_corr.sv
// rtl/ame_grad_corr.sv - per-block Sxx/Syy/Sxy gradient correlation, one row per cycle
// Double-buffered gx/gy capture feeds work registers consumed by a 4-cycle row accumulation.
module ame_grad_corr
  import ame_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      gx_done_i,
  input  grad_blk_t gx_data_i,
  input  logic      gy_done_i,
  input  grad_blk_t gy_data_i,
  output logic      sum_valid_o,
  output sum_t      sxx_o,
  output sum_t      syy_o,
  output sum_t      sxy_o,
  output logic      busy_o,
  output logic      overflow_o
);

  state_e     state_q, state_d;
  logic [1:0] row_q, row_d;
  grad_blk_t  gx_buf_q, gx_buf_d, gy_buf_q, gy_buf_d;
  logic       gx_vld_q, gx_vld_d, gy_vld_q, gy_vld_d;
  grad_blk_t  gx_work_q, gx_work_d, gy_work_q, gy_work_d;
  sum_t       acc_xx_q, acc_xx_d, acc_yy_q, acc_yy_d, acc_xy_q, acc_xy_d;
  sum_t       sxx_q, sxx_d, syy_q, syy_d, sxy_q, sxy_d;
  logic       sum_valid_q, sum_valid_d;
  logic       overflow_q, overflow_d;

  logic       consume;
  grad_row_t  row_gx, row_gy;
  sum_t       part_xx, part_yy, part_xy;

  assign consume = (state_q == IDLE) && gx_vld_q && gy_vld_q;
  assign row_gx  = gx_work_q[row_q];
  assign row_gy  = gy_work_q[row_q];

  ame_grad_row_mac u_row_mac (
    .gx_i (row_gx),
    .gy_i (row_gy),
    .xx_o (part_xx),
    .yy_o (part_yy),
    .xy_o (part_xy)
  );

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    gx_buf_d    = gx_buf_q;
    gy_buf_d    = gy_buf_q;
    gx_vld_d    = gx_vld_q;
    gy_vld_d    = gy_vld_q;
    gx_work_d   = gx_work_q;
    gy_work_d   = gy_work_q;
    acc_xx_d    = acc_xx_q;
    acc_yy_d    = acc_yy_q;
    acc_xy_d    = acc_xy_q;
    sxx_d       = sxx_q;
    syy_d       = syy_q;
    sxy_d       = sxy_q;
    sum_valid_d = 1'b0;
    overflow_d  = overflow_q;

    if (consume) begin
      gx_work_d = gx_buf_q;
      gy_work_d = gy_buf_q;
      gx_vld_d  = 1'b0;
      gy_vld_d  = 1'b0;
      acc_xx_d  = '0;
      acc_yy_d  = '0;
      acc_xy_d  = '0;
      row_d     = 2'd0;
      state_d   = CALC;
    end

    // A done on the consume edge refills the buffer and is not an overrun.
    if (gx_done_i) begin
      gx_buf_d = gx_data_i;
      gx_vld_d = 1'b1;
      if (gx_vld_q && !consume) overflow_d = 1'b1;
    end
    if (gy_done_i) begin
      gy_buf_d = gy_data_i;
      gy_vld_d = 1'b1;
      if (gy_vld_q && !consume) overflow_d = 1'b1;
    end

    if (state_q == CALC) begin
      acc_xx_d = acc_xx_q + part_xx;
      acc_yy_d = acc_yy_q + part_yy;
      acc_xy_d = acc_xy_q + part_xy;
      row_d    = row_q + 2'd1;
      if (row_q == 2'd3) begin
        sxx_d       = acc_xx_d;
        syy_d       = acc_yy_d;
        sxy_d       = acc_xy_d;
        sum_valid_d = 1'b1;
        state_d     = IDLE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      row_q       <= 2'd0;
      gx_buf_q    <= '0;
      gy_buf_q    <= '0;
      gx_vld_q    <= 1'b0;
      gy_vld_q    <= 1'b0;
      gx_work_q   <= '0;
      gy_work_q   <= '0;
      acc_xx_q    <= '0;
      acc_yy_q    <= '0;
      acc_xy_q    <= '0;
      sxx_q       <= '0;
      syy_q       <= '0;
      sxy_q       <= '0;
      sum_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      gx_buf_q    <= gx_buf_d;
      gy_buf_q    <= gy_buf_d;
      gx_vld_q    <= gx_vld_d;
      gy_vld_q    <= gy_vld_d;
      gx_work_q   <= gx_work_d;
      gy_work_q   <= gy_work_d;
      acc_xx_q    <= acc_xx_d;
      acc_yy_q    <= acc_yy_d;
      acc_xy_q    <= acc_xy_d;
      sxx_q       <= sxx_d;
      syy_q       <= syy_d;
      sxy_q       <= sxy_d;
      sum_valid_q <= sum_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign sum_valid_o = sum_valid_q;
  assign sxx_o       = sxx_q;
  assign syy_o       = syy_q;
  assign sxy_o       = sxy_q;
  assign busy_o      = (state_q == CALC);
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_ame_grad_corr.sv
// tb/tb_ame_grad_corr.sv - self-checking bench for ame_grad_corr
// Block-level model predicts each edge; outputs checked every negedge plus literal expectations.
module tb_ame_grad_corr;
  import ame_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  logic      gx_done = 1'b0;
  logic      gy_done = 1'b0;
  grad_blk_t gx_data = '0;
  grad_blk_t gy_data = '0;
  logic      sum_valid, busy, ovf;
  sum_t      sxx, syy, sxy;

  always #5 clk = ~clk;

  ame_grad_corr dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .gx_done_i   (gx_done),
    .gx_data_i   (gx_data),
    .gy_done_i   (gy_done),
    .gy_data_i   (gy_data),
    .sum_valid_o (sum_valid),
    .sxx_o       (sxx),
    .syy_o       (syy),
    .sxy_o       (sxy),
    .busy_o      (busy),
    .overflow_o  (ovf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int busy_cnt = 0;

  // Model state: pending blocks, remaining work edges, visible outputs.
  bit        m_gx_have, m_gy_have, m_valid, m_ovf;
  int        m_left;
  grad_blk_t m_gx, m_gy;
  longint    m_sxx, m_syy, m_sxy, j_xx, j_yy, j_xy;

  typedef struct {
    int     edge_n;
    longint xx;
    longint yy;
    longint xy;
  } pulse_t;
  pulse_t pq[$];

  function automatic longint dot(input grad_blk_t a, input grad_blk_t b);
    longint s;
    grad_t  ea, eb;
    s = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        ea = a[r][c];
        eb = b[r][c];
        s += longint'(ea) * longint'(eb);
      end
    return s;
  endfunction

  function automatic grad_blk_t fill(input int v);
    grad_blk_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = grad_t'(v);
    return b;
  endfunction

  function automatic grad_blk_t ramp();
    grad_blk_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) b[r][c] = grad_t'(r * 4 + c);
    return b;
  endfunction

  function automatic grad_blk_t mk(input int i, input bit is_y);
    grad_blk_t b;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        b[r][c] = is_y ? grad_t'(i * 3 - r * 7 + c * 13 - 20)
                       : grad_t'(i * 37 + r * 5 - c * 11);
    return b;
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0d, want %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_update();
    bit consume;
    cyc++;
    if (rst) begin
      m_gx_have = 0; m_gy_have = 0; m_valid = 0; m_ovf = 0; m_left = 0;
      m_sxx = 0; m_syy = 0; m_sxy = 0;
      return;
    end
    m_valid = 0;
    consume = (m_left == 0) && m_gx_have && m_gy_have;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_sxx = j_xx; m_syy = j_yy; m_sxy = j_xy; m_valid = 1;
      end
    end else if (consume) begin
      j_xx = dot(m_gx, m_gx);
      j_yy = dot(m_gy, m_gy);
      j_xy = dot(m_gx, m_gy);
      m_left = 4;
    end
    if (gx_done) begin
      if (m_gx_have && !consume) m_ovf = 1;
      m_gx = gx_data; m_gx_have = 1;
    end else if (consume) m_gx_have = 0;
    if (gy_done) begin
      if (m_gy_have && !consume) m_ovf = 1;
      m_gy = gy_data; m_gy_have = 1;
    end else if (consume) m_gy_have = 0;
  endtask

  task automatic compare_cycle();
    pulse_t p;
    chk("sum_valid", longint'(sum_valid), longint'(m_valid));
    chk("busy", longint'(busy), longint'(m_left > 0));
    chk("overflow", longint'(ovf), longint'(m_ovf));
    chk("sxx", sxx, m_sxx);
    chk("syy", syy, m_syy);
    chk("sxy", sxy, m_sxy);
    if (sum_valid) begin
      p.edge_n = cyc; p.xx = sxx; p.yy = syy; p.xy = sxy;
      pq.push_back(p);
    end
    if (busy) busy_cnt++;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    gx_done = 1'b0;
    gy_done = 1'b0;
    @(negedge clk);
    compare_cycle();
  endtask

  task automatic chk_pulse(input string nm, input int idx, input int edge_exp,
                           input longint xx, input longint yy, input longint xy);
    if (pq.size() <= idx) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: pulse %0d missing, got %0d pulses, want more", nm, idx, pq.size());
      return;
    end
    chk({nm, ".edge"}, pq[idx].edge_n, edge_exp);
    chk({nm, ".sxx"}, pq[idx].xx, xx);
    chk({nm, ".syy"}, pq[idx].yy, yy);
    chk({nm, ".sxy"}, pq[idx].xy, xy);
  endtask

  initial begin
    int e, t;
    repeat (3) step();
    rst = 1'b0;
    step();

    // gx all +1, gy all +2 two edges later
    pq.delete();
    gx_data = fill(1); gy_data = fill(2);
    gx_done = 1'b1; step();
    step();
    gy_done = 1'b1; step(); e = cyc;
    repeat (8) step();
    chk("t1.npulse", pq.size(), 1);
    chk_pulse("t1", 0, e + 5, 16, 64, 32);
    chk("t1.ovf", longint'(ovf), 0);

    // extreme values, simultaneous dones
    pq.delete(); busy_cnt = 0;
    gx_data = fill(-1020); gy_data = fill(1020);
    gx_done = 1'b1; gy_done = 1'b1; step(); e = cyc;
    repeat (8) step();
    chk("t2.npulse", pq.size(), 1);
    chk_pulse("t2", 0, e + 5, 16646400, 16646400, -16646400);
    chk("t2.busy_cycles", busy_cnt, 4);

    // ramp gx, then gy arriving 3 edges before gx
    pq.delete();
    gx_data = ramp(); gy_data = fill(1);
    gx_done = 1'b1; gy_done = 1'b1; step(); e = cyc;
    repeat (8) step();
    chk_pulse("t3a", 0, e + 5, 1240, 16, 120);
    pq.delete();
    gx_data = fill(2); gy_data = fill(3);
    gy_done = 1'b1; step();
    step(); step();
    gx_done = 1'b1; step(); e = cyc;
    repeat (10) step();
    chk("t3b.npulse", pq.size(), 1);
    chk_pulse("t3b", 0, e + 5, 64, 144, 96);

    // back-to-back with a gx done landing on the consume edge
    pq.delete();
    gx_data = mk(0, 0); gy_data = mk(0, 1);
    gx_done = 1'b1; gy_done = 1'b1; step(); t = cyc;
    gx_data = mk(1, 0); gx_done = 1'b1; step();
    step();
    gy_data = mk(1, 1); gy_done = 1'b1; step();
    repeat (3) step();
    gx_data = mk(2, 0); gy_data = mk(2, 1);
    gx_done = 1'b1; gy_done = 1'b1; step();
    repeat (6) step();
    gx_data = mk(3, 0); gy_data = mk(3, 1);
    gx_done = 1'b1; gy_done = 1'b1; step();
    repeat (8) step();
    chk("t4.npulse", pq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk_pulse($sformatf("t4.blk%0d", i), i, t + 5 * (i + 1),
                dot(mk(i, 0), mk(i, 0)), dot(mk(i, 1), mk(i, 1)), dot(mk(i, 0), mk(i, 1)));
    chk("t4.ovf", longint'(ovf), 0);

    // overrun: gx A then gx B before gy
    pq.delete();
    gx_data = fill(5); gx_done = 1'b1; step();
    step();
    gx_data = fill(3); gx_done = 1'b1; step();
    step();
    gy_data = fill(1); gy_done = 1'b1; step(); e = cyc;
    repeat (8) step();
    chk("t5.ovf", longint'(ovf), 1);
    chk_pulse("t5", 0, e + 5, 144, 16, 48);
    repeat (5) step();
    chk("t5.ovf_sticky", longint'(ovf), 1);

    // reset during the 2nd CALC cycle, then a fresh block
    rst = 1'b1; step(); rst = 1'b0;
    chk("t6.ovf_cleared", longint'(ovf), 0);
    pq.delete(); busy_cnt = 0;
    gx_data = fill(7); gy_data = fill(7);
    gx_done = 1'b1; gy_done = 1'b1; step();
    step(); step();
    rst = 1'b1; gy_data = fill(9); gy_done = 1'b1; step();
    rst = 1'b0;
    repeat (6) step();
    chk("t6.npulse", pq.size(), 0);
    chk("t6.sxx", sxx, 0);
    chk("t6.syy", syy, 0);
    chk("t6.sxy", sxy, 0);
    chk("t6.busy", longint'(busy), 0);
    chk("t6.busy_cycles", busy_cnt, 2);
    gx_data = fill(1); gy_data = fill(-1);
    gx_done = 1'b1; gy_done = 1'b1; step(); e = cyc;
    repeat (8) step();
    chk_pulse("t6", 0, e + 5, 16, 16, -16);
    chk("t6.ovf", longint'(ovf), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
